// File: rtl/pressure_pkg.sv
// Shared definitions for the pressure alarm monitor: FSM encoding, default
// qualification thresholds and the run-counter width.
package pressure_pkg;

    localparam int RUN_W           = 4;
    localparam int DEF_TRIP_COUNT  = 4;
    localparam int DEF_CLEAR_COUNT = 8;
    localparam int DEF_TIMEOUT     = 1000;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ALARM   = 2'd2,
        ST_ACKED   = 2'd3
    } state_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v,
                                                 input logic [RUN_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/pressure_watchdog.sv
// Sensor stall detector: raises sensor_fault once TIMEOUT consecutive cycles
// pass without sample_valid; the next sample clears it.
module pressure_watchdog #(
    parameter int TIMEOUT = pressure_pkg::DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_valid,
    output logic sensor_fault
);
    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] watchdog_n;

    always_comb begin
        watchdog_n = watchdog;
        if (sample_valid) begin
            watchdog_n = '0;
        end else if (watchdog != WD_MAX) begin
            watchdog_n = watchdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            watchdog     <= '0;
            sensor_fault <= 1'b0;
        end else begin
            watchdog     <= watchdog_n;
            sensor_fault <= (watchdog_n == WD_MAX);
        end
    end

endmodule

// File: rtl/pressure_alarm_monitor.sv
// Qualifies the analyzer's per-sample health bit into a latched, acknowledgeable
// alarm with a stalled-sensor flag and a saturating alarm-event counter.
module pressure_alarm_monitor
    import pressure_pkg::*;
#(
    parameter int TRIP_COUNT  = DEF_TRIP_COUNT,
    parameter int CLEAR_COUNT = DEF_CLEAR_COUNT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic       pressure_ok,
    input  logic       alarm_ack,
    output logic       alarm,
    output logic       buzzer,
    output logic       sensor_fault,
    output logic [1:0] state,
    output logic [7:0] alarm_events
);
    localparam logic [RUN_W-1:0] TRIP_LIM  = RUN_W'(TRIP_COUNT);
    localparam logic [RUN_W-1:0] CLEAR_LIM = RUN_W'(CLEAR_COUNT);

    state_t           state_q, state_n;
    logic [RUN_W-1:0] bad_run, bad_run_n;
    logic [RUN_W-1:0] good_run, good_run_n;
    logic [RUN_W-1:0] good_upd;
    logic [7:0]       events_n;
    logic             enter_alarm;
    logic             bad, good;

    assign bad   = sample_valid & ~pressure_ok;
    assign good  = sample_valid &  pressure_ok;
    assign state = state_q;

    pressure_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sensor_fault (sensor_fault)
    );

    // Samples update good_run before any ack decision looks at it.
    assign good_upd = good ? sat_inc(good_run, CLEAR_LIM)
                           : (bad ? '0 : good_run);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n     = state_q;
        bad_run_n   = bad_run;
        good_run_n  = good_run;
        events_n    = alarm_events;
        enter_alarm = 1'b0;

        case (state_q)
            ST_NORMAL: begin
                if (bad) begin
                    if (TRIP_COUNT == 1) begin
                        enter_alarm = 1'b1;
                    end else begin
                        state_n   = ST_SUSPECT;
                        bad_run_n = RUN_W'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                if (bad) begin
                    if (bad_run + 1'b1 == TRIP_LIM) enter_alarm = 1'b1;
                    else                            bad_run_n   = bad_run + 1'b1;
                end else if (good) begin
                    state_n   = ST_NORMAL;
                    bad_run_n = '0;
                end
            end
            ST_ALARM: begin
                good_run_n = good_upd;
                if (alarm_ack) begin
                    state_n = (good_upd >= CLEAR_LIM) ? ST_NORMAL : ST_ACKED;
                end
            end
            ST_ACKED: begin
                good_run_n = good_upd;
                if (good_upd >= CLEAR_LIM) state_n = ST_NORMAL;
            end
            default: state_n = ST_NORMAL;
        endcase

        if (enter_alarm) begin
            state_n    = ST_ALARM;
            good_run_n = '0;
            if (alarm_events != 8'hFF) events_n = alarm_events + 8'd1;
        end

        if (state_n == ST_NORMAL) begin
            bad_run_n  = '0;
            good_run_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            bad_run      <= '0;
            good_run     <= '0;
            alarm_events <= '0;
            alarm        <= 1'b0;
            buzzer       <= 1'b0;
        end else begin
            state_q      <= state_n;
            bad_run      <= bad_run_n;
            good_run     <= good_run_n;
            alarm_events <= events_n;
            alarm        <= (state_n == ST_ALARM) || (state_n == ST_ACKED);
            buzzer       <= (state_n == ST_ALARM);
        end
    end

endmodule

// File: tb/tb_pressure_alarm_monitor.sv
// Directed self-checking bench for pressure_alarm_monitor with default
// parameters (TRIP_COUNT 4, CLEAR_COUNT 8, TIMEOUT 1000).
module tb_pressure_alarm_monitor;

    localparam int IDLE     = 0;
    localparam int GOOD     = 1;
    localparam int BAD      = 2;
    localparam int ACK      = 3;
    localparam int GOOD_ACK = 4;
    localparam int BAD_ACK  = 5;

    typedef struct {
        int code;
        int st;
        int ev;
    } step_t;

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic       pressure_ok;
    logic       alarm_ack;
    logic       alarm;
    logic       buzzer;
    logic       sensor_fault;
    logic [1:0] state;
    logic [7:0] alarm_events;

    int n_cmp = 0;
    int n_bad = 0;

    pressure_alarm_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .pressure_ok  (pressure_ok),
        .alarm_ack    (alarm_ack),
        .alarm        (alarm),
        .buzzer       (buzzer),
        .sensor_fault (sensor_fault),
        .state        (state),
        .alarm_events (alarm_events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed/expected vector layout: {state[1:0], alarm, buzzer, sensor_fault, events[7:0]}
    function automatic logic [12:0] obs();
        return {state, alarm, buzzer, sensor_fault, alarm_events};
    endfunction

    function automatic logic [12:0] mk(input int st, input int ev, input bit sf);
        logic [1:0] s;
        logic [7:0] e;
        s = st[1:0];
        e = ev[7:0];
        return {s, (st == 2) || (st == 3), st == 2, sf, e};
    endfunction

    function automatic step_t stp(input int c, input int s, input int e);
        step_t r;
        r.code = c;
        r.st   = s;
        r.ev   = e;
        return r;
    endfunction

    task automatic drive(input logic v, input logic ok, input logic ack);
        sample_valid = v;
        pressure_ok  = ok;
        alarm_ack    = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int code);
        case (code)
            GOOD:     drive(1'b1, 1'b1, 1'b0);
            BAD:      drive(1'b1, 1'b0, 1'b0);
            ACK:      drive(1'b0, 1'b0, 1'b1);
            GOOD_ACK: drive(1'b1, 1'b1, 1'b1);
            BAD_ACK:  drive(1'b1, 1'b0, 1'b1);
            default:  drive(1'b0, 1'b0, 1'b0);
        endcase
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom));
            e = mk(0, 0, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs(), e);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_trip_abort();
        step_t q[$];
        logic [12:0] e;
        q.push_back(stp(BAD, 1, 0));
        q.push_back(stp(BAD, 1, 0));
        q.push_back(stp(BAD, 1, 0));
        q.push_back(stp(GOOD, 0, 0));
        foreach (q[i]) begin
            apply(q[i].code);
            e = mk(q[i].st, q[i].ev, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL trip_abort[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_trip();
        step_t q[$];
        logic [12:0] e;
        q.push_back(stp(BAD, 1, 0));
        q.push_back(stp(IDLE, 1, 0));
        q.push_back(stp(BAD, 1, 0));
        q.push_back(stp(IDLE, 1, 0));
        q.push_back(stp(BAD, 1, 0));
        q.push_back(stp(BAD, 2, 1));
        q.push_back(stp(GOOD, 2, 1));
        foreach (q[i]) begin
            apply(q[i].code);
            e = mk(q[i].st, q[i].ev, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL trip[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    // Enters with ALARM and good_run=1 from test_trip.
    task automatic test_clear();
        step_t q[$];
        logic [12:0] e;
        q.push_back(stp(GOOD, 2, 1));
        q.push_back(stp(ACK, 3, 1));
        q.push_back(stp(ACK, 3, 1));
        for (int i = 0; i < 5; i++) q.push_back(stp(GOOD, 3, 1));
        q.push_back(stp(GOOD, 0, 1));
        for (int i = 0; i < 4; i++) q.push_back(stp(BAD, (i < 3) ? 1 : 2, (i < 3) ? 1 : 2));
        q.push_back(stp(ACK, 3, 2));
        for (int i = 0; i < 3; i++) q.push_back(stp(GOOD, 3, 2));
        q.push_back(stp(BAD_ACK, 3, 2));
        for (int i = 0; i < 7; i++) q.push_back(stp(GOOD, 3, 2));
        q.push_back(stp(GOOD_ACK, 0, 2));
        foreach (q[i]) begin
            apply(q[i].code);
            e = mk(q[i].st, q[i].ev, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL clear[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_early_clear();
        step_t q[$];
        logic [12:0] e;
        for (int i = 0; i < 4; i++) q.push_back(stp(BAD, (i < 3) ? 1 : 2, (i < 3) ? 2 : 3));
        for (int i = 0; i < 10; i++) q.push_back(stp(GOOD, 2, 3));
        q.push_back(stp(ACK, 0, 3));
        for (int i = 0; i < 4; i++) q.push_back(stp(BAD, (i < 3) ? 1 : 2, (i < 3) ? 3 : 4));
        for (int i = 0; i < 7; i++) q.push_back(stp(GOOD, 2, 4));
        q.push_back(stp(GOOD_ACK, 0, 4));
        for (int i = 0; i < 4; i++) q.push_back(stp(BAD, (i < 3) ? 1 : 2, (i < 3) ? 4 : 5));
        for (int i = 0; i < 7; i++) q.push_back(stp(GOOD, 2, 5));
        q.push_back(stp(BAD_ACK, 3, 5));
        foreach (q[i]) begin
            apply(q[i].code);
            e = mk(q[i].st, q[i].ev, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL early_clear[%0d]: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    // Enters in ACKED with the alarm raised; a single reset edge must drop everything.
    task automatic test_reset_mid_alarm();
        logic [12:0] e;
        for (int i = 0; i < 2; i++) apply(BAD);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
        e = mk(0, 0, 1'b0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_mid_alarm: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_saturation();
        logic [12:0] e;
        int exp_ev;
        exp_ev = 0;
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < 4; i++) apply(BAD);
            if (exp_ev < 255) exp_ev++;
            e = mk(2, exp_ev, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL saturation_trip[%0d]: got %h expected %h", k, obs(), e);
            end
            for (int i = 0; i < 8; i++) apply(GOOD);
            apply(ACK);
            e = mk(0, exp_ev, 1'b0);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL saturation_clear[%0d]: got %h expected %h", k, obs(), e);
            end
        end
    endtask

    // Enters in NORMAL with alarm_events saturated at 255.
    task automatic test_watchdog();
        logic [12:0] e;
        apply(BAD);
        apply(BAD);
        for (int i = 1; i <= 1004; i++) begin
            apply(IDLE);
            if (i == 999 || i >= 1000) begin
                e = mk(1, 255, i >= 1000);
                n_cmp++;
                if (obs() !== e) begin
                    n_bad++;
                    $display("FAIL watchdog_idle[%0d]: got %h expected %h", i, obs(), e);
                end
            end
        end
        apply(BAD);
        e = mk(1, 255, 1'b0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL watchdog_sample: got %h expected %h", obs(), e);
        end
        apply(BAD);
        e = mk(2, 255, 1'b0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL watchdog_run_held: got %h expected %h", obs(), e);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        pressure_ok  = 1'b0;
        alarm_ack    = 1'b0;
        test_reset();
        test_trip_abort();
        test_trip();
        test_clear();
        test_early_clear();
        test_reset_mid_alarm();
        test_saturation();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
